dbus_wb_bridge: RTL and testbench
=================================

DBUS_WB_BRIDGE -- requirements
Module: dbus_wb_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the maximum number of cycles the block waits for a bus acknowledge.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 mem_addr_mem  input  32  byte address of the MEM-stage access.
REQ-005 mem_wdata_mem  input  32  store data, right-aligned.
REQ-006 mem_write_mem  input  1  store request.
REQ-007 mem_read_mem  input  1  load request.
REQ-008 mem_op_mem  input  3  access size/sign: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-009 mem_rdata_mem  output  32  aligned, extended load result.
REQ-010 stall_pipl  output  1  holds the core pipeline while an access is in flight.
REQ-011 dbus_err  output  1  one-cycle pulse for a bus error, timeout or misaligned access.
REQ-012 wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  Wishbone classic master controls.
REQ-013 wb_adr_o  output  32  word-aligned address, bits [1:0] = 0.
REQ-014 wb_dat_o  output  32  lane-replicated store data.
REQ-015 wb_sel_o  output  4  byte-lane selects.
REQ-016 wb_dat_i  input  32  read data.
REQ-017 wb_ack_i, wb_err_i  input  1 each  cycle termination signals.

Function
REQ-018 The FSM SHALL have exactly three states, IDLE, BUS and DONE.
REQ-019 A request is mem_read_mem | mem_write_mem; when both are high, the access SHALL be a write.
REQ-020 In IDLE with a request, the block SHALL move to BUS and register cyc, stb, we, adr, sel and dat, so they are visible the next cycle.
REQ-021 Misaligned accesses (half with addr[0]=1, word with addr[1:0]!=0) SHALL go IDLE->DONE with no bus cycle, dbus_err=1 and mem_rdata_mem=0.
REQ-022 In BUS, wb_ack_i or wb_err_i SHALL drop cyc/stb on the next edge and move the FSM to DONE; if both are high, err wins.
REQ-023 A timeout counter SHALL clear on entry to BUS and increment each BUS cycle; at TIMEOUT_CYCLES it SHALL terminate the access as an error.
REQ-024 In DONE, for exactly one cycle: stall_pipl=0, the registered load result is valid, and dbus_err is high if an error occurred; the FSM then returns to IDLE.
REQ-025 stall_pipl SHALL be combinational: (IDLE & request) | BUS.
REQ-026 The core advances the MEM stage in every cycle stall_pipl is low, so DONE never re-issues the same request.
REQ-027 Store lanes:
- byte: sel = 1 << addr[1:0], data = {4{wdata[7:0]}}.
- half: sel = 0011 or 1100 by addr[1], data = {2{wdata[15:0]}}.
- word: sel = 1111.
REQ-028 Load data SHALL be shifted right by 8*addr[1:0], then sign- or zero-extended per mem_op_mem; write accesses SHALL return 0.
REQ-029 Minimum access latency SHALL be 2 stall cycles when the slave acks in the first stb cycle.
REQ-030 In IDLE with no request, all Wishbone outputs SHALL be 0.

Reset
REQ-031 On reset_n low, the FSM SHALL go to IDLE immediately and asynchronously, including in mid-cycle.
REQ-032 During reset, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, mem_rdata_mem, dbus_err and the timeout counter SHALL all be 0.
REQ-033 While reset_n is low, stall_pipl SHALL be 0.

Structure
REQ-034 The mem_op encodings (enum), the FSM state typedef and the default timeout constant SHALL live in shared package core_pkg.
REQ-035 Load alignment and extension SHALL be one combinational sub-module, dbus_load_align (inputs: raw data, addr[1:0], op; output: result).

Verification
REQ-036 LW at 0x100, slave acks in the first stb cycle with 0xDEADBEEF -> stall high for 2 cycles, then mem_rdata_mem=0xDEADBEEF for one cycle, dbus_err=0.
REQ-037 LB at 0x103 with wb_dat_i=0x80123456 -> 0xFFFFFF80; LBU at the same address -> 0x00000080; LHU at 0x102 -> 0x00008012.
REQ-038 SH at 0x202 with wdata=0x0000ABCD -> wb_sel_o=1100, wb_dat_o=0xABCDABCD, wb_adr_o=0x200, wb_we_o=1.
REQ-039 LW at 0x101 -> no wb_cyc_o, one-cycle stall, dbus_err pulse, result 0.
REQ-040 Slave never acks with TIMEOUT_CYCLES=8 -> cyc drops after 8 BUS cycles, DONE with dbus_err=1; a following request issues normally.
REQ-041 reset_n driven low in the second BUS cycle -> cyc, stb and stall go to 0 at once; after release, the next request completes correctly.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the data-bus side of the core.
//   mem_op_e      : MEM-stage access size/sign encodings
//   mem_size_e    : access width derived from a mem_op
//   dbus_state_e  : bridge FSM states
//   DBUS_TIMEOUT_DEFAULT : default bus-acknowledge timeout in cycles
//   op_size()     : width of an access from mem_op[1:0]
//   misaligned()  : true when the address is not naturally aligned
package core_pkg;

   typedef enum logic [2:0] {
      MEM_B  = 3'b000,
      MEM_H  = 3'b001,
      MEM_W  = 3'b010,
      MEM_BU = 3'b100,
      MEM_HU = 3'b101
   } mem_op_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } mem_size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_DONE = 2'd2
   } dbus_state_e;

   localparam int DBUS_TIMEOUT_DEFAULT = 255;

   // op[2] only selects sign handling; the width lives in op[1:0].
   // Undefined encodings fall back to a word access.
   function automatic mem_size_e op_size(input logic [1:0] op_lo);
      case (op_lo)
         2'b00:   return SZ_BYTE;
         2'b01:   return SZ_HALF;
         default: return SZ_WORD;
      endcase
   endfunction

   function automatic logic misaligned(input logic [1:0] op_lo, input logic [1:0] lsb);
      case (op_size(op_lo))
         SZ_HALF: return lsb[0];
         SZ_WORD: return |lsb;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dbus_wb_bridge_if.sv
// Wishbone classic bus between the data-bus bridge (master) and a slave.
//   wb_cyc_o, wb_stb_o, wb_we_o : cycle, strobe, write enable
//   wb_adr_o                    : word-aligned byte address
//   wb_dat_o, wb_sel_o          : store data and byte-lane selects
//   wb_dat_i                    : read data
//   wb_ack_i, wb_err_i          : cycle termination
interface dbus_wb_bridge_if;

   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_err_i;

   modport master (
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
      input  wb_dat_i, wb_ack_i, wb_err_i
   );

   modport slave (
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
      output wb_dat_i, wb_ack_i, wb_err_i
   );

endinterface

// File: rtl/dbus_load_align.sv
// Load data alignment: shifts the raw bus word down to the addressed byte
// lane and sign- or zero-extends it according to the access op.
//   raw      : 32-bit word from the bus
//   addr_lsb : byte offset of the access within the word
//   op       : mem_op encoding (op[2] set = unsigned)
//   result   : aligned, extended load value
module dbus_load_align
   import core_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [1:0]  addr_lsb,
   input  logic [2:0]  op,
   output logic [31:0] result
);

   logic [31:0] shifted;

   always_comb begin
      shifted = raw >> {addr_lsb, 3'b000};
      result  = shifted;
      case (op_size(op[1:0]))
         SZ_BYTE: result = {{24{shifted[7] & ~op[2]}}, shifted[7:0]};
         SZ_HALF: result = {{16{shifted[15] & ~op[2]}}, shifted[15:0]};
         default: result = shifted;
      endcase
   end

endmodule

// File: rtl/dbus_wb_bridge.sv
// Bridge from the core MEM stage to a Wishbone classic master port.
// One access at a time: IDLE issues, BUS waits for ack/err/timeout,
// DONE presents the result for one cycle while the pipeline advances.
//   clk, reset_n            : clock, asynchronous active-low reset
//   mem_addr_mem .. op_mem  : MEM-stage request
//   mem_rdata_mem           : load result, valid in the DONE cycle
//   stall_pipl              : holds the pipeline while an access is in flight
//   dbus_err                : one-cycle pulse on bus error, timeout or misalignment
//   wb                      : Wishbone master port
module dbus_wb_bridge
   import core_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DBUS_TIMEOUT_DEFAULT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [31:0]      mem_addr_mem,
   input  logic [31:0]      mem_wdata_mem,
   input  logic             mem_write_mem,
   input  logic             mem_read_mem,
   input  logic [2:0]       mem_op_mem,
   output logic [31:0]      mem_rdata_mem,
   output logic             stall_pipl,
   output logic             dbus_err,
   dbus_wb_bridge_if.master wb
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   dbus_state_e      state_q, state_d;
   logic             req, misal, tmo_hit, bus_fail, bus_end;
   logic [3:0]       sel_d;
   logic [31:0]      dat_d;
   logic [CNT_W-1:0] tmo_cnt;
   logic [2:0]       op_q;
   logic [1:0]       lsb_q;
   logic [31:0]      load_res;
   logic             cyc_q, stb_q, we_q, err_q;
   logic [31:0]      adr_q, dat_q, rdata_q;
   logic [3:0]       sel_q;

   assign req      = mem_read_mem | mem_write_mem;
   assign misal    = misaligned(mem_op_mem[1:0], mem_addr_mem[1:0]);
   // The last permitted BUS cycle; a simultaneous ack still completes normally.
   assign tmo_hit  = (tmo_cnt == TMO_LAST);
   assign bus_fail = wb.wb_err_i | (tmo_hit & ~wb.wb_ack_i);
   assign bus_end  = wb.wb_ack_i | bus_fail;

   // Gated by reset_n so the pipeline is released while reset is held.
   assign stall_pipl = reset_n & (((state_q == ST_IDLE) & req) | (state_q == ST_BUS));

   // Store lane placement: data replicated across lanes, sel picks the target.
   always_comb begin
      sel_d = 4'b1111;
      dat_d = mem_wdata_mem;
      case (op_size(mem_op_mem[1:0]))
         SZ_BYTE: begin
            sel_d = 4'b0001 << mem_addr_mem[1:0];
            dat_d = {4{mem_wdata_mem[7:0]}};
         end
         SZ_HALF: begin
            sel_d = mem_addr_mem[1] ? 4'b1100 : 4'b0011;
            dat_d = {2{mem_wdata_mem[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (req) state_d = misal ? ST_DONE : ST_BUS;
         ST_BUS:  if (bus_end) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Bus outputs, timeout counter and the one-cycle DONE result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         op_q    <= '0;
         lsb_q   <= '0;
         tmo_cnt <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         // Result and error only live for the DONE cycle.
         rdata_q <= '0;
         err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req && misal) begin
                  err_q <= 1'b1;
               end else if (req) begin
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  we_q    <= mem_write_mem;
                  adr_q   <= {mem_addr_mem[31:2], 2'b00};
                  dat_q   <= dat_d;
                  sel_q   <= sel_d;
                  op_q    <= mem_op_mem;
                  lsb_q   <= mem_addr_mem[1:0];
                  tmo_cnt <= '0;
               end
            end
            ST_BUS: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (bus_end) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  we_q    <= 1'b0;
                  adr_q   <= '0;
                  dat_q   <= '0;
                  sel_q   <= '0;
                  err_q   <= bus_fail;
                  rdata_q <= (we_q | bus_fail) ? '0 : load_res;
               end
            end
            default: ;
         endcase
      end
   end

   dbus_load_align u_align (
      .raw      (wb.wb_dat_i),
      .addr_lsb (lsb_q),
      .op       (op_q),
      .result   (load_res)
   );

   assign wb.wb_cyc_o   = cyc_q;
   assign wb.wb_stb_o   = stb_q;
   assign wb.wb_we_o    = we_q;
   assign wb.wb_adr_o   = adr_q;
   assign wb.wb_dat_o   = dat_q;
   assign wb.wb_sel_o   = sel_q;
   assign mem_rdata_mem = rdata_q;
   assign dbus_err      = err_q;

endmodule

// File: tb/tb_dbus_wb_bridge.sv
// Testbench for dbus_wb_bridge: directed scenarios plus randomized accesses
// checked against a behavioural model of access width, lanes and extension.
module tb_dbus_wb_bridge;
   import core_pkg::*;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] mem_addr_mem = '0;
   logic [31:0] mem_wdata_mem = '0;
   logic        mem_write_mem = 1'b0;
   logic        mem_read_mem = 1'b0;
   logic [2:0]  mem_op_mem = 3'b010;
   logic [31:0] mem_rdata_mem;
   logic        stall_pipl;
   logic        dbus_err;

   dbus_wb_bridge_if wb_if ();

   dbus_wb_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .mem_addr_mem  (mem_addr_mem),
      .mem_wdata_mem (mem_wdata_mem),
      .mem_write_mem (mem_write_mem),
      .mem_read_mem  (mem_read_mem),
      .mem_op_mem    (mem_op_mem),
      .mem_rdata_mem (mem_rdata_mem),
      .stall_pipl    (stall_pipl),
      .dbus_err      (dbus_err),
      .wb            (wb_if)
   );

   always #5 clk = ~clk;

   // Slave: terminates after slave_lat wait cycles (-1 = never).
   // slave_mode 0 = ack, 1 = err, 2 = ack and err together.
   int          slave_lat = 0;
   int          slave_mode = 0;
   int          wait_cnt;
   logic [31:0] slave_data = '0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)              wait_cnt <= 0;
      else if (!wb_if.wb_cyc_o)  wait_cnt <= 0;
      else                       wait_cnt <= wait_cnt + 1;
   end

   assign wb_if.wb_ack_i = wb_if.wb_cyc_o && wb_if.wb_stb_o && (slave_lat >= 0) &&
                           (wait_cnt == slave_lat) && (slave_mode != 1);
   assign wb_if.wb_err_i = wb_if.wb_cyc_o && wb_if.wb_stb_o && (slave_lat >= 0) &&
                           (wait_cnt == slave_lat) && (slave_mode != 0);
   assign wb_if.wb_dat_i = slave_data;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      int          stalls;
      int          cyc_cycles;
      bit          done;
      bit          saw_cyc;
      bit          err_early;
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [31:0] rdata;
      logic        err;
      logic        err_after;
      logic        cyc_after;
      logic        stall_after;
   } obs_t;

   // ---------------- reference model ----------------
   function automatic int size_of(input logic [2:0] op);
      case (op[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit exp_misal(input logic [2:0] op, input logic [31:0] addr);
      return (int'(addr[1:0]) % size_of(op)) != 0;
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] raw, input logic [31:0] addr,
                                            input logic [2:0] op);
      longint v;
      int     s;
      s = size_of(op);
      v = longint'(raw) >> (8 * int'(addr[1:0]));
      v = v % (longint'(1) << (8 * s));
      if (!op[2] && s < 4 && v >= (longint'(1) << (8 * s - 1)))
         v = v - (longint'(1) << (8 * s));
      return v[31:0];
   endfunction

   function automatic logic [3:0] exp_sel(input logic [2:0] op, input logic [31:0] addr);
      logic [3:0] s;
      int lo;
      s  = '0;
      lo = int'(addr[1:0]);
      for (int i = 0; i < 4; i++)
         if (i >= lo && i < lo + size_of(op)) s[i] = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] exp_dat(input logic [2:0] op, input logic [31:0] wdata);
      logic [31:0] d;
      for (int i = 0; i < 4; i++)
         d[8*i +: 8] = wdata[8*(i % size_of(op)) +: 8];
      return d;
   endfunction

   // ---------------- access driver ----------------
   task automatic do_access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                            input bit wr, input bit rd, input int lat, input int mode,
                            input logic [31:0] sdata, output obs_t o);
      o = '{default: 0};
      slave_lat  = lat;
      slave_mode = mode;
      slave_data = sdata;
      @(posedge clk); #1;
      mem_op_mem    = op;
      mem_addr_mem  = addr;
      mem_wdata_mem = wdata;
      mem_write_mem = wr;
      mem_read_mem  = rd;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (wb_if.wb_cyc_o) o.cyc_cycles++;
         if (stall_pipl) begin
            o.stalls++;
            if (dbus_err) o.err_early = 1;
            if (wb_if.wb_cyc_o && !o.saw_cyc) begin
               o.saw_cyc = 1;
               o.we  = wb_if.wb_we_o;
               o.adr = wb_if.wb_adr_o;
               o.dat = wb_if.wb_dat_o;
               o.sel = wb_if.wb_sel_o;
            end
         end else begin
            o.done  = 1;
            o.rdata = mem_rdata_mem;
            o.err   = dbus_err;
            break;
         end
      end
      @(posedge clk); #1;
      mem_write_mem = 1'b0;
      mem_read_mem  = 1'b0;
      mem_addr_mem  = $urandom;
      @(negedge clk);
      o.err_after   = dbus_err;
      o.cyc_after   = wb_if.wb_cyc_o | wb_if.wb_stb_o;
      o.stall_after = stall_pipl;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      reset_n      = 1'b0;
      mem_read_mem = 1'b1;
      mem_addr_mem = 32'h100;
      #23;
      tests_run++;
      if (stall_pipl !== 1'b0) begin
         tests_failed++; $display("FAIL reset_stall: got %b expected 0", stall_pipl);
      end
      tests_run++;
      if ({wb_if.wb_cyc_o, wb_if.wb_stb_o, wb_if.wb_we_o, wb_if.wb_adr_o, wb_if.wb_dat_o, wb_if.wb_sel_o} !== '0) begin
         tests_failed++; $display("FAIL reset_bus: got cyc=%b adr=%h expected all zero", wb_if.wb_cyc_o, wb_if.wb_adr_o);
      end
      tests_run++;
      if ({mem_rdata_mem, dbus_err} !== 33'd0) begin
         tests_failed++; $display("FAIL reset_result: got rdata=%h err=%b expected 0", mem_rdata_mem, dbus_err);
      end
      mem_read_mem = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_load_word;
      obs_t o;
      do_access(3'b010, 32'h100, 32'h0, 1'b0, 1'b1, 0, 0, 32'hDEADBEEF, o);
      tests_run++;
      if (o.stalls !== 2) begin tests_failed++; $display("FAIL lw_stalls: got %0d expected 2", o.stalls); end
      tests_run++;
      if (o.rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL lw_rdata: got %h expected deadbeef", o.rdata); end
      tests_run++;
      if (o.err !== 1'b0) begin tests_failed++; $display("FAIL lw_err: got %b expected 0", o.err); end
      tests_run++;
      if (o.adr !== 32'h100 || o.we !== 1'b0) begin
         tests_failed++; $display("FAIL lw_bus: got adr=%h we=%b expected 00000100 0", o.adr, o.we);
      end
      tests_run++;
      if (o.err_after !== 1'b0 || o.cyc_after !== 1'b0) begin
         tests_failed++; $display("FAIL lw_idle: got err=%b cyc=%b expected 0 0", o.err_after, o.cyc_after);
      end
   endtask

   task automatic test_load_extend;
      obs_t o;
      do_access(3'b000, 32'h103, 32'h0, 1'b0, 1'b1, 0, 0, 32'h80123456, o);
      tests_run++;
      if (o.rdata !== 32'hFFFFFF80) begin tests_failed++; $display("FAIL lb_rdata: got %h expected ffffff80", o.rdata); end
      do_access(3'b100, 32'h103, 32'h0, 1'b0, 1'b1, 1, 0, 32'h80123456, o);
      tests_run++;
      if (o.rdata !== 32'h00000080) begin tests_failed++; $display("FAIL lbu_rdata: got %h expected 00000080", o.rdata); end
      do_access(3'b101, 32'h102, 32'h0, 1'b0, 1'b1, 0, 0, 32'h80123456, o);
      tests_run++;
      if (o.rdata !== 32'h00008012) begin tests_failed++; $display("FAIL lhu_rdata: got %h expected 00008012", o.rdata); end
   endtask

   task automatic test_store_half;
      obs_t o;
      do_access(3'b001, 32'h202, 32'h0000ABCD, 1'b1, 1'b0, 0, 0, 32'h12345678, o);
      tests_run++;
      if (o.sel !== 4'b1100) begin tests_failed++; $display("FAIL sh_sel: got %b expected 1100", o.sel); end
      tests_run++;
      if (o.dat !== 32'hABCDABCD) begin tests_failed++; $display("FAIL sh_dat: got %h expected abcdabcd", o.dat); end
      tests_run++;
      if (o.adr !== 32'h200 || o.we !== 1'b1) begin
         tests_failed++; $display("FAIL sh_bus: got adr=%h we=%b expected 00000200 1", o.adr, o.we);
      end
      tests_run++;
      if (o.rdata !== 32'h0) begin tests_failed++; $display("FAIL sh_rdata: got %h expected 0", o.rdata); end
   endtask

   task automatic test_misaligned;
      obs_t o;
      do_access(3'b010, 32'h101, 32'h0, 1'b0, 1'b1, 0, 0, 32'hCAFEF00D, o);
      tests_run++;
      if (o.saw_cyc !== 1'b0) begin tests_failed++; $display("FAIL mis_cyc: got %b expected 0", o.saw_cyc); end
      tests_run++;
      if (o.stalls !== 1) begin tests_failed++; $display("FAIL mis_stalls: got %0d expected 1", o.stalls); end
      tests_run++;
      if (o.err !== 1'b1 || o.err_after !== 1'b0) begin
         tests_failed++; $display("FAIL mis_err: got %b then %b expected 1 then 0", o.err, o.err_after);
      end
      tests_run++;
      if (o.rdata !== 32'h0) begin tests_failed++; $display("FAIL mis_rdata: got %h expected 0", o.rdata); end
   endtask

   task automatic test_bus_error;
      obs_t o;
      do_access(3'b010, 32'h400, 32'h0, 1'b0, 1'b1, 1, 2, 32'h11111111, o);
      tests_run++;
      if (o.err !== 1'b1 || o.stalls !== 3) begin
         tests_failed++; $display("FAIL err_wins: got err=%b stalls=%0d expected 1 3", o.err, o.stalls);
      end
   endtask

   task automatic test_timeout;
      obs_t o;
      do_access(3'b010, 32'h500, 32'h0, 1'b0, 1'b1, -1, 0, 32'h0, o);
      tests_run++;
      if (o.cyc_cycles !== TMO) begin tests_failed++; $display("FAIL tmo_cyc: got %0d expected %0d", o.cyc_cycles, TMO); end
      tests_run++;
      if (o.stalls !== TMO + 1 || o.err !== 1'b1) begin
         tests_failed++; $display("FAIL tmo_done: got stalls=%0d err=%b expected %0d 1", o.stalls, o.err, TMO + 1);
      end
      do_access(3'b010, 32'h504, 32'h0, 1'b0, 1'b1, 0, 0, 32'h5A5AA5A5, o);
      tests_run++;
      if (o.rdata !== 32'h5A5AA5A5 || o.err !== 1'b0 || o.stalls !== 2) begin
         tests_failed++; $display("FAIL tmo_next: got rdata=%h err=%b stalls=%0d expected 5a5aa5a5 0 2", o.rdata, o.err, o.stalls);
      end
   endtask

   task automatic test_reset_mid;
      obs_t o;
      slave_lat  = -1;
      slave_mode = 0;
      @(posedge clk); #1;
      mem_op_mem   = 3'b010;
      mem_addr_mem = 32'h300;
      mem_read_mem = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (wb_if.wb_cyc_o !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_cyc: got %b expected 1", wb_if.wb_cyc_o); end
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      tests_run++;
      if ({wb_if.wb_cyc_o, wb_if.wb_stb_o, stall_pipl} !== 3'b000) begin
         tests_failed++; $display("FAIL rst_mid: got cyc=%b stb=%b stall=%b expected 0 0 0", wb_if.wb_cyc_o, wb_if.wb_stb_o, stall_pipl);
      end
      mem_read_mem = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      do_access(3'b000, 32'h305, 32'h0, 1'b0, 1'b1, 1, 0, 32'h00007F00, o);
      tests_run++;
      if (o.rdata !== 32'h0000007F || o.err !== 1'b0 || o.stalls !== 3) begin
         tests_failed++; $display("FAIL rst_after: got rdata=%h err=%b stalls=%0d expected 0000007f 0 3", o.rdata, o.err, o.stalls);
      end
   endtask

   task automatic test_random;
      obs_t        o;
      logic [2:0]  ops [5];
      logic [2:0]  op;
      logic [31:0] addr, wdata, sdata;
      bit          wr, rd, misal, berr;
      int          k, lat, mode, exp_stalls;
      ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      for (int n = 0; n < 60; n++) begin
         op    = ops[$urandom_range(0, 4)];
         addr  = $urandom;
         wdata = $urandom;
         sdata = $urandom;
         k     = int'($urandom_range(0, 2));
         wr    = (k != 0);
         rd    = (k != 1);
         lat   = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
         k     = int'($urandom_range(0, 9));
         mode  = (k == 0) ? 1 : (k == 1) ? 2 : 0;
         do_access(op, addr, wdata, wr, rd, lat, mode, sdata, o);
         misal      = exp_misal(op, addr);
         berr       = !misal && (lat < 0 || mode != 0);
         exp_stalls = misal ? 1 : 1 + ((lat < 0) ? TMO : lat + 1);
         tests_run++;
         if (o.stalls !== exp_stalls || o.saw_cyc !== !misal) begin
            tests_failed++;
            $display("FAIL rnd_latency[%0d]: got stalls=%0d cyc=%b expected %0d %b", n, o.stalls, o.saw_cyc, exp_stalls, !misal);
         end
         tests_run++;
         if (o.err !== (misal || berr) || o.err_early !== 1'b0 || o.err_after !== 1'b0) begin
            tests_failed++;
            $display("FAIL rnd_err[%0d]: got %b/%b/%b expected %b/0/0", n, o.err_early, o.err, o.err_after, misal || berr);
         end
         tests_run++;
         if (o.cyc_after !== 1'b0 || o.stall_after !== 1'b0) begin
            tests_failed++; $display("FAIL rnd_idle[%0d]: got cyc=%b stall=%b expected 0 0", n, o.cyc_after, o.stall_after);
         end
         if (!misal) begin
            tests_run++;
            if (o.we !== wr || o.adr !== {addr[31:2], 2'b00}) begin
               tests_failed++; $display("FAIL rnd_bus[%0d]: got we=%b adr=%h expected %b %h", n, o.we, o.adr, wr, {addr[31:2], 2'b00});
            end
         end
         if (!misal && wr) begin
            tests_run++;
            if (o.sel !== exp_sel(op, addr) || o.dat !== exp_dat(op, wdata)) begin
               tests_failed++;
               $display("FAIL rnd_store[%0d]: got sel=%b dat=%h expected %b %h", n, o.sel, o.dat, exp_sel(op, addr), exp_dat(op, wdata));
            end
         end
         if (!berr) begin
            tests_run++;
            if (o.rdata !== ((misal || wr) ? 32'h0 : exp_load(sdata, addr, op))) begin
               tests_failed++;
               $display("FAIL rnd_rdata[%0d]: got %h expected %h", n, o.rdata, (misal || wr) ? 32'h0 : exp_load(sdata, addr, op));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_word();
      test_load_extend();
      test_store_half();
      test_misaligned();
      test_bus_error();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
